// File: rtl/tilt_cursor_draw.sv
// Hollow-square cursor source for the shared frame-buffer write bus.
// Steps its position once per grant from the tilt inputs, then rasters the square one pixel per clock.
module tilt_cursor_draw #(
  parameter int           SOURCE_ID    = 3,
  parameter logic [8:0]   CURSOR_COLOR = 9'b111000000,
  parameter int           CURSOR_SIZE  = 8,
  parameter int           DRAW_WIDTH   = 160,
  parameter int           DRAW_HEIGHT  = 120,
  parameter int           X_ADDRW      = 8,
  parameter int           Y_ADDRW      = 7,
  parameter int           SRC_ADDRW    = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [3:0]           tilt_amount_x,
  input  logic [3:0]           tilt_amount_y,
  input  logic                 tilt_direction_x,
  input  logic                 tilt_direction_y,
  input  logic [SRC_ADDRW-1:0] write_source_sel,
  input  logic                 write_awaited,
  output tri                   write_active,
  output tri   [X_ADDRW-1:0]   write_x_addr,
  output tri   [Y_ADDRW-1:0]   write_y_addr,
  output tri   [8:0]           write_color_data,
  output tri                   write_transparent
);

  localparam int CNT_W = $clog2(CURSOR_SIZE);
  localparam int MAX_X = DRAW_WIDTH - CURSOR_SIZE;
  localparam int MAX_Y = DRAW_HEIGHT - CURSOR_SIZE;
  localparam logic [X_ADDRW-1:0] CX_RESET = X_ADDRW'(MAX_X / 2);
  localparam logic [Y_ADDRW-1:0] CY_RESET = Y_ADDRW'(MAX_Y / 2);
  localparam logic signed [X_ADDRW+1:0] MAX_XS = (X_ADDRW+2)'(MAX_X);
  localparam logic signed [Y_ADDRW+1:0] MAX_YS = (Y_ADDRW+2)'(MAX_Y);

  typedef enum logic [1:0] {IDLE, MOVE, DRAW, DONE} state_t;

  state_t             state;
  logic [X_ADDRW-1:0] cx;
  logic [Y_ADDRW-1:0] cy;
  logic [CNT_W-1:0]   px;
  logic [CNT_W-1:0]   py;

  logic               grant;
  logic               drive;
  logic               border;
  logic [X_ADDRW-1:0] x_pix;
  logic [Y_ADDRW-1:0] y_pix;

  // Signed step with two guard bits so underflow below 0 and overshoot past the edge both clamp.
  function automatic logic [X_ADDRW-1:0] step_x(input logic [X_ADDRW-1:0] pos,
                                                input logic [3:0] amt, input logic neg);
    logic signed [X_ADDRW+1:0] d;
    logic signed [X_ADDRW+1:0] s;
    d = $signed({{(X_ADDRW-2){1'b0}}, amt});
    if (neg) d = -d;
    s = $signed({2'b00, pos}) + d;
    if (s[X_ADDRW+1])  return '0;
    else if (s > MAX_XS) return MAX_X[X_ADDRW-1:0];
    else                 return s[X_ADDRW-1:0];
  endfunction

  function automatic logic [Y_ADDRW-1:0] step_y(input logic [Y_ADDRW-1:0] pos,
                                                input logic [3:0] amt, input logic neg);
    logic signed [Y_ADDRW+1:0] d;
    logic signed [Y_ADDRW+1:0] s;
    d = $signed({{(Y_ADDRW-2){1'b0}}, amt});
    if (neg) d = -d;
    s = $signed({2'b00, pos}) + d;
    if (s[Y_ADDRW+1])  return '0;
    else if (s > MAX_YS) return MAX_Y[Y_ADDRW-1:0];
    else                 return s[Y_ADDRW-1:0];
  endfunction

  assign grant = (write_source_sel == SRC_ADDRW'(SOURCE_ID)) && write_awaited;
  assign drive = grant && resetN;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      cx    <= CX_RESET;
      cy    <= CY_RESET;
      px    <= '0;
      py    <= '0;
    end else begin
      case (state)
        IDLE: if (grant) state <= MOVE;
        MOVE: begin
          if (!grant) begin
            state <= IDLE;
          end else begin
            cx    <= step_x(cx, tilt_amount_x, tilt_direction_x);
            cy    <= step_y(cy, tilt_amount_y, tilt_direction_y);
            px    <= '0;
            py    <= '0;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (!grant) begin
            state <= IDLE;
          end else begin
            px <= px + CNT_W'(1);
            if (px == '1) begin
              py <= py + CNT_W'(1);
              if (py == '1) state <= DONE;
            end
          end
        end
        DONE: if (!grant) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel outputs decode only registered state, so tilt inputs never reach the bus combinationally.
  assign x_pix  = cx + {{(X_ADDRW-CNT_W){1'b0}}, px};
  assign y_pix  = cy + {{(Y_ADDRW-CNT_W){1'b0}}, py};
  assign border = (px == '0) || (py == '0) || (px == '1) || (py == '1);

  assign write_active      = drive ? (state == DRAW) : 1'bz;
  assign write_x_addr      = drive ? x_pix : 'z;
  assign write_y_addr      = drive ? y_pix : 'z;
  assign write_color_data  = drive ? CURSOR_COLOR : 'z;
  assign write_transparent = drive ? ((state == DRAW) ? !border : 1'b1) : 1'bz;

endmodule

// File: tb/tb_tilt_cursor_draw.sv
// Bench for tilt_cursor_draw: table of tilt steps with expected cursor origin, scoreboarded pixel bursts,
// plus hand sequences for foreign-source, held grant and mid-draw reset.
module tb_tilt_cursor_draw;

  localparam int SRC = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] tilt_amount_x = '0, tilt_amount_y = '0;
  logic       tilt_direction_x = 1'b0, tilt_direction_y = 1'b0;
  logic [1:0] write_source_sel = '0;
  logic       write_awaited = 1'b0;
  wire        write_active;
  wire  [7:0] write_x_addr;
  wire  [6:0] write_y_addr;
  wire  [8:0] write_color_data;
  wire        write_transparent;

  tilt_cursor_draw dut (
    .clk(clk), .resetN(resetN),
    .tilt_amount_x(tilt_amount_x), .tilt_amount_y(tilt_amount_y),
    .tilt_direction_x(tilt_direction_x), .tilt_direction_y(tilt_direction_y),
    .write_source_sel(write_source_sel), .write_awaited(write_awaited),
    .write_active(write_active), .write_x_addr(write_x_addr), .write_y_addr(write_y_addr),
    .write_color_data(write_color_data), .write_transparent(write_transparent)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [3:0] ax; logic dx; logic [3:0] ay; logic dy; int ex; int ey;
  } vec_t;
  typedef struct { int x; int y; bit t; } pix_t;

  pix_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   max_x = 0, max_y = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A 2-state simulator reads an undriven bus as all zeros.
  function automatic bit hiz_x(input logic [7:0] v);
    return (v === 8'bz) || (v === 8'b0);
  endfunction
  function automatic bit hiz_1(input logic v);
    return (v === 1'bz) || (v === 1'b0);
  endfunction

  task automatic step();
    @(posedge clk);
    #5;
  endtask

  task automatic check_released(input string name);
    check(hiz_1(write_active), {name, "_active_z"}, int'(write_active), 0);
    check(hiz_x(write_x_addr), {name, "_xaddr_z"}, int'(write_x_addr), 0);
  endtask

  // Grants the bus, expects one 64-pixel burst at origin (ex,ey); leaves the grant held in DONE.
  task automatic draw(input logic [3:0] ax, input logic dx, input logic [3:0] ay, input logic dy,
                      input int ex, input int ey, input string tag);
    int act, first;
    pix_t e;
    tilt_amount_x = ax; tilt_direction_x = dx;
    tilt_amount_y = ay; tilt_direction_y = dy;
    write_source_sel = SRC; write_awaited = 1'b1;
    q.delete();
    for (int py = 0; py < 8; py++)
      for (int px = 0; px < 8; px++)
        q.push_back('{ex + px, ey + py, !(px == 0 || py == 0 || px == 7 || py == 7)});
    act = 0; first = -1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      step();
      if (write_active === 1'b1) begin
        if (first < 0) first = cyc;
        act++;
        if (int'(write_x_addr) > max_x) max_x = int'(write_x_addr);
        if (int'(write_y_addr) > max_y) max_y = int'(write_y_addr);
        if (q.size() == 0) begin
          check(1'b0, {tag, "_extra_pixel"}, act, 64);
        end else begin
          e = q.pop_front();
          check(int'(write_x_addr) == e.x, {tag, "_x"}, int'(write_x_addr), e.x);
          check(int'(write_y_addr) == e.y, {tag, "_y"}, int'(write_y_addr), e.y);
          check(write_transparent === e.t, {tag, "_transp"}, int'(write_transparent), int'(e.t));
          check(write_color_data === 9'b111000000, {tag, "_color"}, int'(write_color_data), 9'h1c0);
        end
      end else if (act > 0) begin
        break;
      end
    end
    check(first == 2, {tag, "_first_pixel_cycle"}, first, 2);
    check(act == 64, {tag, "_burst_len"}, act, 64);
    check(write_active === 1'b0, {tag, "_done_low"}, int'(write_active), 0);
  endtask

  task automatic release_bus();
    write_awaited = 1'b0;
    step();
  endtask

  vec_t vecs[$];

  initial begin
    int act, seen;

    vecs = '{
      '{4'd0,  1'b0, 4'd0,  1'b0, 76,  56},
      '{4'd5,  1'b0, 4'd0,  1'b0, 81,  56},
      '{4'd15, 1'b1, 4'd0,  1'b0, 66,  56},
      '{4'd15, 1'b1, 4'd0,  1'b0, 51,  56},
      '{4'd15, 1'b1, 4'd0,  1'b0, 36,  56},
      '{4'd15, 1'b1, 4'd0,  1'b0, 21,  56},
      '{4'd15, 1'b1, 4'd0,  1'b0, 6,   56},
      '{4'd15, 1'b1, 4'd0,  1'b0, 0,   56},
      '{4'd15, 1'b0, 4'd15, 1'b0, 15,  71},
      '{4'd15, 1'b0, 4'd15, 1'b0, 30,  86},
      '{4'd15, 1'b0, 4'd15, 1'b0, 45,  101},
      '{4'd15, 1'b0, 4'd15, 1'b0, 60,  112},
      '{4'd15, 1'b0, 4'd15, 1'b0, 75,  112},
      '{4'd15, 1'b0, 4'd15, 1'b0, 90,  112},
      '{4'd15, 1'b0, 4'd15, 1'b0, 105, 112},
      '{4'd15, 1'b0, 4'd15, 1'b0, 120, 112},
      '{4'd15, 1'b0, 4'd15, 1'b0, 135, 112},
      '{4'd15, 1'b0, 4'd15, 1'b0, 150, 112},
      '{4'd15, 1'b0, 4'd15, 1'b0, 152, 112},
      '{4'd15, 1'b0, 4'd15, 1'b0, 152, 112},
      '{4'd3,  1'b1, 4'd15, 1'b1, 149, 97}
    };

    // Reset: bus released, even with a grant present while reset is held.
    step();
    check_released("reset");
    write_source_sel = SRC; write_awaited = 1'b1;
    #1;
    check_released("reset_granted");
    write_awaited = 1'b0;
    step();
    resetN = 1'b1;
    step();
    check_released("idle");

    foreach (vecs[i]) begin
      draw(vecs[i].ax, vecs[i].dx, vecs[i].ay, vecs[i].dy, vecs[i].ex, vecs[i].ey, $sformatf("vec%0d", i));
      if (i == 19) begin
        check(max_x == 159, "max_x_addr", max_x, 159);
        check(max_y == 119, "max_y_addr", max_y, 119);
      end
      release_bus();
      check_released("after_draw");
    end

    // Another source owns the bus: stay released and keep the position.
    write_source_sel = 2'd2; write_awaited = 1'b1;
    tilt_amount_x = 4'd9; tilt_amount_y = 4'd9;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!hiz_1(write_active) || !hiz_x(write_x_addr)) seen++;
    end
    check(seen == 0, "foreign_sel_z", seen, 0);
    write_awaited = 1'b0;
    step();
    draw(4'd0, 1'b0, 4'd0, 1'b0, 149, 97, "after_foreign");

    // Grant held long after DONE yields no second burst until the grant drops.
    act = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (write_active === 1'b1) act++;
    end
    check(act == 0, "held_grant_no_redraw", act, 0);
    check(write_active === 1'b0, "held_grant_active_low", int'(write_active), 0);
    release_bus();
    draw(4'd0, 1'b0, 4'd0, 1'b0, 149, 97, "regrant");
    release_bus();

    // Reset in the middle of a burst.
    tilt_amount_x = 4'd0; tilt_amount_y = 4'd0;
    write_source_sel = SRC; write_awaited = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && seen < 20; c++) begin
      step();
      if (write_active === 1'b1) seen++;
    end
    check(seen == 20, "reach_pixel20", seen, 20);
    resetN = 1'b0;
    #1;
    check_released("mid_draw_reset");
    write_awaited = 1'b0;
    step();
    resetN = 1'b1;
    step();
    draw(4'd0, 1'b0, 4'd0, 1'b0, 76, 56, "post_reset");
    release_bus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
